// File: rtl/sif_wr_bridge.sv
// sif_wr_bridge: X-side register file whose writes are also forwarded to the W side through a FIFO.
// Define SIF_DROP_CNT_EN to add the saturating drop_cnt[7:0] output.
module sif_wr_bridge #(
  parameter int DW         = 16,
  parameter int AW         = 16,
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          xa_wr_s,
  input  logic          xa_rd_s,
  input  logic [AW-1:0] xa_addr,
  input  logic [DW-1:0] xa_data_wr,
  output logic [DW-1:0] xa_data_rd,
  output logic          xa_full,
  input  logic          wa_rdy,
  output logic          wa_wr_s,
  output logic [AW-1:0] wa_addr,
  output logic [DW-1:0] wa_data_wr,
  output logic          ovf,
  input  logic          ovf_clr
`ifdef SIF_DROP_CNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam int NREG = 2**IDX_W;
  localparam int FA   = $clog2(FIFO_DEPTH);
  localparam int PW   = FA + 1;

  logic [DW-1:0]    r_rf [NREG];
  logic [AW+DW-1:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [DW-1:0]    r_data_rd;
  logic [AW-1:0]    r_last_addr;
  logic [DW-1:0]    r_last_data;
  logic             r_ovf;

  logic             w_in_rng;
  logic [IDX_W-1:0] w_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [AW+DW-1:0] w_head;

  assign w_idx    = xa_addr[IDX_W-1:0];
  assign w_in_rng = (xa_addr[AW-1:IDX_W] == '0);
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
  assign w_pop    = !w_empty && wa_rdy;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push   = xa_wr_s && (!w_full || w_pop);
  assign w_drop   = xa_wr_s && w_full && !w_pop;
  assign w_head   = r_fifo[r_rptr[FA-1:0]];

  assign wa_wr_s    = w_pop;
  assign wa_addr    = w_empty ? r_last_addr : w_head[AW+DW-1:DW];
  assign wa_data_wr = w_empty ? r_last_data : w_head[DW-1:0];
  assign xa_full    = w_full;
  assign xa_data_rd = r_data_rd;
  assign ovf        = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_data_rd   <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_last_addr <= '0;
      r_last_data <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (xa_wr_s && w_in_rng) r_rf[w_idx] <= xa_data_wr;
      if (xa_rd_s) r_data_rd <= w_in_rng ? r_rf[w_idx] : '0;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr      <= r_rptr + 1'b1;
        r_last_addr <= w_head[AW+DW-1:DW];
        r_last_data <= w_head[DW-1:0];
      end
      if (w_drop) r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[FA-1:0]] <= {xa_addr, xa_data_wr};
  end

`ifdef SIF_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_drop_cnt <= 8'd0;
    else if (w_drop) begin
      if (ovf_clr) r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (ovf_clr) r_drop_cnt <= 8'd0;
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_sif_wr_bridge.sv
// Scoreboard bench for sif_wr_bridge: stimulus queues expected W-side writes and read data,
// a negedge monitor pops and compares whenever the DUT strobes wa_wr_s or returns read data.
module tb_sif_wr_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        xa_wr_s = 1'b0;
  logic        xa_rd_s = 1'b0;
  logic [15:0] xa_addr = '0;
  logic [15:0] xa_data_wr = '0;
  logic [15:0] xa_data_rd;
  logic        xa_full;
  logic        wa_rdy = 1'b0;
  logic        wa_wr_s;
  logic [15:0] wa_addr;
  logic [15:0] wa_data_wr;
  logic        ovf;
  logic        ovf_clr = 1'b0;
`ifdef SIF_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  sif_wr_bridge dut (
    .clk(clk), .rst(rst),
    .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr),
    .xa_data_wr(xa_data_wr), .xa_data_rd(xa_data_rd), .xa_full(xa_full),
    .wa_rdy(wa_rdy), .wa_wr_s(wa_wr_s), .wa_addr(wa_addr), .wa_data_wr(wa_data_wr),
    .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef SIF_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [31:0] wq[$];
  logic [15:0] rq[$];
  bit          mon_en  = 1'b0;
  bit          rd_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic miss(input string nm);
    n_tot++;
    $display("FAIL %s: DUT output with nothing expected at %0t", nm, $time);
  endtask

  // Monitor: read data returns after the edge that sampled xa_rd_s; wa_wr_s pops at the coming edge.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [15:0] r;
    if (mon_en) begin
      if (rd_pend) begin
        if (rq.size() == 0) miss("xa_data_rd");
        else begin
          r = rq.pop_front();
          chk("xa_data_rd", {16'h0, xa_data_rd}, {16'h0, r});
        end
      end
      rd_pend = (xa_rd_s === 1'b1);
      if (wa_wr_s === 1'b1) begin
        if (wq.size() == 0) miss("wa_wr_s");
        else begin
          e = wq.pop_front();
          chk("wa_addr", {16'h0, wa_addr}, {16'h0, e[31:16]});
          chk("wa_data_wr", {16'h0, wa_data_wr}, {16'h0, e[15:0]});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit fwd, input bit clr);
    xa_wr_s = 1'b1; xa_addr = a; xa_data_wr = d; ovf_clr = clr;
    if (fwd) wq.push_back({a, d});
    step();
    xa_wr_s = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp);
    xa_rd_s = 1'b1; xa_addr = a;
    rq.push_back(exp);
    step();
    xa_rd_s = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    chk("rst_wa_wr_s", {31'h0, wa_wr_s}, 32'h0);
    chk("rst_xa_full", {31'h0, xa_full}, 32'h0);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    chk("rst_xa_data_rd", {16'h0, xa_data_rd}, 32'h0);
    chk("rst_wa_addr", {16'h0, wa_addr}, 32'h0);
    chk("rst_wa_data_wr", {16'h0, wa_data_wr}, 32'h0);
    mon_en = 1'b1;

    // single forwarded write, visible the cycle after it is accepted
    wa_rdy = 1'b1;
    wr(16'h0003, 16'hA5A5, 1'b1, 1'b0);
    chk("lat_wa_wr_s", {31'h0, wa_wr_s}, 32'h1);
    step();
    chk("empty_wa_wr_s", {31'h0, wa_wr_s}, 32'h0);
    chk("empty_hold_addr", {16'h0, wa_addr}, 32'h3);

    // fill with back-pressure, fifth write dropped from the FIFO only
    wa_rdy = 1'b0;
    for (int i = 0; i < 4; i++) wr(16'(4 + i), 16'(16'h0100 + i), 1'b1, 1'b0);
    chk("fill_xa_full", {31'h0, xa_full}, 32'h1);
    chk("fill_ovf", {31'h0, ovf}, 32'h0);
    wr(16'h0008, 16'h0104, 1'b0, 1'b0);
    chk("drop_ovf", {31'h0, ovf}, 32'h1);
    step();
    chk("stall_wa_addr", {16'h0, wa_addr}, 32'h4);
    chk("stall_wa_data", {16'h0, wa_data_wr}, 32'h0100);
    wa_rdy = 1'b1;
    repeat (6) step();
    chk("drain1_left", wq.size(), 32'h0);
    chk("drain1_hold_addr", {16'h0, wa_addr}, 32'h7);
    chk("drain1_hold_data", {16'h0, wa_data_wr}, 32'h0103);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("clr_ovf", {31'h0, ovf}, 32'h0);

    // full FIFO, push and pop in the same cycle
    wa_rdy = 1'b0;
    for (int i = 0; i < 4; i++) wr(16'(9 + i), 16'(16'h0200 + i), 1'b1, 1'b0);
    chk("fill2_xa_full", {31'h0, xa_full}, 32'h1);
    wa_rdy = 1'b1;
    wr(16'h000D, 16'h0204, 1'b1, 1'b0);
    chk("pp_ovf", {31'h0, ovf}, 32'h0);
    chk("pp_xa_full", {31'h0, xa_full}, 32'h1);
    repeat (6) step();
    chk("drain2_left", wq.size(), 32'h0);

    // reads, out-of-range access, read/write collision
    wr(16'h0007, 16'h1234, 1'b1, 1'b0);
    rd(16'h0007, 16'h1234);
    step();
    chk("rd_hold", {16'h0, xa_data_rd}, 32'h1234);
    wr(16'h0010, 16'hBEEF, 1'b1, 1'b0);
    rd(16'h0010, 16'h0000);
    rd(16'h0000, 16'h0000);
    rd(16'h0008, 16'h0104);
    wr(16'h0002, 16'h0001, 1'b1, 1'b0);
    xa_rd_s = 1'b1;
    rq.push_back(16'h0001);
    wr(16'h0002, 16'h0002, 1'b1, 1'b0);
    xa_rd_s = 1'b0;
    rd(16'h0002, 16'h0002);
    repeat (3) step();
    chk("drain3_left", wq.size(), 32'h0);

    // drop coinciding with ovf_clr: set wins
    wa_rdy = 1'b0;
    for (int i = 0; i < 4; i++) wr(16'h0001, 16'(16'h0300 + i), 1'b1, 1'b0);
    wr(16'h0001, 16'h0304, 1'b0, 1'b1);
    chk("setwins_ovf", {31'h0, ovf}, 32'h1);
`ifdef SIF_DROP_CNT_EN
    chk("setwins_drop_cnt", {24'h0, drop_cnt}, 32'h1);
    for (int i = 0; i < 300; i++) wr(16'h0001, 16'(i), 1'b0, 1'b0);
    chk("sat_drop_cnt", {24'h0, drop_cnt}, 32'hFF);
`endif
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("clr2_ovf", {31'h0, ovf}, 32'h0);
`ifdef SIF_DROP_CNT_EN
    chk("clr_drop_cnt", {24'h0, drop_cnt}, 32'h0);
`endif
    wa_rdy = 1'b1;
    repeat (6) step();
    chk("drain4_left", wq.size(), 32'h0);

    // reset with queued entries discards them
    wa_rdy = 1'b0;
    wr(16'h0003, 16'h0401, 1'b1, 1'b0);
    wr(16'h0005, 16'h0402, 1'b1, 1'b0);
    wr(16'h0006, 16'h0403, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wq.delete();
    wa_rdy = 1'b1;
    chk("rst2_wa_wr_s", {31'h0, wa_wr_s}, 32'h0);
    chk("rst2_xa_full", {31'h0, xa_full}, 32'h0);
    chk("rst2_wa_addr", {16'h0, wa_addr}, 32'h0);
    rd(16'h0003, 16'h0000);
    repeat (3) step();
    chk("end_wq_left", wq.size(), 32'h0);
    chk("end_rq_left", rq.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
